// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: WD source selects, load funct3
// codes and the default datapath width.
package wb_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W_DEF = 64;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC4 = 2'd2;
  localparam logic [1:0] WDSEL_IMM = 2'd3;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load alignment and sign/zero extension of a raw aligned
// memory word; shared with the MEM-stage forwarding path.
module wb_stage_load_extend
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] mrd,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      ldtype,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mrd[{addr_lo, 3'b000} +: 8];
  // addr_lo[0] is ignored for halfword accesses.
  assign half_sel = addr_lo[1] ? mrd[31:16] : mrd[15:0];

  always_comb begin
    ext = mrd;
    case (ldtype)
      LD_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      LD_LW:   ext = mrd;
      default: ext = mrd;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: drives the register file
// write port one cycle after MEM and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_rfwr,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wdsel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mrd,
  input  logic [1:0]       in_addr_lo,
  input  logic [2:0]       in_ldtype,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             stall,
  input  logic             flush,
  output logic             RFWr,
  output logic [4:0]       A3,
  output logic [XLEN-1:0]  WD,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_pc,
  output logic [CNT_W-1:0] instret
);

  logic             valid_reg;
  logic             rfwr_reg;
  logic [4:0]       rd_reg;
  logic [1:0]       wdsel_reg;
  logic [XLEN-1:0]  alu_reg;
  logic [XLEN-1:0]  mrd_reg;
  logic [1:0]       addr_lo_reg;
  logic [2:0]       ldtype_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [XLEN-1:0]  imm_reg;
  logic [CNT_W-1:0] instret_reg;
  logic [XLEN-1:0]  load_val;
  logic             capture;

  assign capture = !flush && !stall;

  // Flush only needs to kill valid/rfwr; the payload fields keep their values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      rfwr_reg    <= 1'b0;
      rd_reg      <= '0;
      wdsel_reg   <= '0;
      alu_reg     <= '0;
      mrd_reg     <= '0;
      addr_lo_reg <= '0;
      ldtype_reg  <= '0;
      pc_reg      <= '0;
      imm_reg     <= '0;
    end else if (flush) begin
      valid_reg   <= 1'b0;
      rfwr_reg    <= 1'b0;
    end else if (!stall) begin
      valid_reg   <= in_valid;
      rfwr_reg    <= in_rfwr;
      rd_reg      <= in_rd;
      wdsel_reg   <= in_wdsel;
      alu_reg     <= in_alu;
      mrd_reg     <= in_mrd;
      addr_lo_reg <= in_addr_lo;
      ldtype_reg  <= in_ldtype;
      pc_reg      <= in_pc;
      imm_reg     <= in_imm;
    end
  end

  // Counted at capture so a later stall of the same instruction is not recounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (capture && in_valid) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  wb_stage_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .mrd     (mrd_reg),
    .addr_lo (addr_lo_reg),
    .ldtype  (ldtype_reg),
    .ext     (load_val)
  );

  always_comb begin
    WD = alu_reg;
    case (wdsel_reg)
      WDSEL_ALU: WD = alu_reg;
      WDSEL_MEM: WD = load_val;
      WDSEL_PC4: WD = pc_reg + XLEN'(4);
      WDSEL_IMM: WD = imm_reg;
      default:   WD = alu_reg;
    endcase
  end

  assign RFWr     = valid_reg && rfwr_reg && (rd_reg != 5'd0);
  assign A3       = rd_reg;
  assign wb_valid = valid_reg;
  assign wb_pc    = pc_reg;
  assign instret  = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expected values.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_rfwr;
  logic [4:0]  in_rd;
  logic [1:0]  in_wdsel;
  logic [31:0] in_alu;
  logic [31:0] in_mrd;
  logic [1:0]  in_addr_lo;
  logic [2:0]  in_ldtype;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic        stall;
  logic        flush;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [63:0] instret;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_cnt;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_rfwr    (in_rfwr),
    .in_rd      (in_rd),
    .in_wdsel   (in_wdsel),
    .in_alu     (in_alu),
    .in_mrd     (in_mrd),
    .in_addr_lo (in_addr_lo),
    .in_ldtype  (in_ldtype),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .stall      (stall),
    .flush      (flush),
    .RFWr       (RFWr),
    .A3         (A3),
    .WD         (WD),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [1:0] lo,
                       input logic [2:0] ldt, input logic [31:0] pc,
                       input logic [31:0] imm);
    in_valid   = v;
    in_rfwr    = wr;
    in_rd      = rd;
    in_wdsel   = sel;
    in_alu     = alu;
    in_mrd     = mrd;
    in_addr_lo = lo;
    in_ldtype  = ldt;
    in_pc      = pc;
    in_imm     = imm;
  endtask

  // One captured load of mrd=0x80FF7F01 with the given offset/type.
  task automatic load_case(input string tag, input logic [1:0] lo,
                           input logic [2:0] ldt, input logic [31:0] exp_wd);
    drive(1'b1, 1'b1, 5'd7, 2'd1, 32'h0, 32'h80FF7F01, lo, ldt, 32'h200, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk(tag, {32'h0, WD}, {32'h0, exp_wd});
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    exp_cnt = 64'd0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);
    #12;
    chk("rst_wb_valid", {63'h0, wb_valid}, 64'd0);
    chk("rst_rfwr", {63'h0, RFWr}, 64'd0);
    chk("rst_a3", {59'h0, A3}, 64'd0);
    chk("rst_wd", {32'h0, WD}, 64'd0);
    chk("rst_wb_pc", {32'h0, wb_pc}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU write then bubble
    drive(1'b1, 1'b1, 5'd5, 2'd0, 32'h12345678, 32'h0, 2'd0, 3'd0, 32'h40, 32'h0);
    step();
    exp_cnt = 64'd1;
    chk("alu_rfwr", {63'h0, RFWr}, 64'd1);
    chk("alu_a3", {59'h0, A3}, 64'd5);
    chk("alu_wd", {32'h0, WD}, 64'h12345678);
    chk("alu_instret", instret, 64'd1);
    chk("alu_wb_pc", {32'h0, wb_pc}, 64'h40);
    drive(1'b0, 1'b1, 5'd5, 2'd0, 32'h12345678, 32'h0, 2'd0, 3'd0, 32'h44, 32'h0);
    step();
    chk("bubble_rfwr", {63'h0, RFWr}, 64'd0);
    chk("bubble_valid", {63'h0, wb_valid}, 64'd0);
    chk("bubble_instret", instret, 64'd1);

    // Load extension
    load_case("lb_lo3",   2'd3, 3'b000, 32'hFFFFFF80);
    load_case("lbu_lo1",  2'd1, 3'b100, 32'h0000007F);
    load_case("lh_lo2",   2'd2, 3'b001, 32'hFFFF80FF);
    load_case("lhu_lo0",  2'd0, 3'b101, 32'h00007F01);
    load_case("lh_lo3",   2'd3, 3'b001, 32'hFFFF80FF);
    load_case("lw",       2'd2, 3'b010, 32'h80FF7F01);
    load_case("ld_011",   2'd1, 3'b011, 32'h80FF7F01);
    chk("load_instret", instret, exp_cnt);

    // x0 and source select
    drive(1'b1, 1'b1, 5'd0, 2'd0, 32'hDEADBEEF, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("x0_rfwr", {63'h0, RFWr}, 64'd0);
    chk("x0_valid", {63'h0, wb_valid}, 64'd1);
    drive(1'b1, 1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 2'd0, 3'd0, 32'h00000100, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("pc4_wd", {32'h0, WD}, 64'h104);
    chk("pc4_rfwr", {63'h0, RFWr}, 64'd1);
    drive(1'b1, 1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 2'd0, 3'd0, 32'hFFFFFFFC, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("pc4_wrap_wd", {32'h0, WD}, 64'h0);
    drive(1'b1, 1'b1, 5'd2, 2'd3, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 32'hABCDE000);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("imm_wd", {32'h0, WD}, 64'hABCDE000);
    chk("sel_instret", instret, exp_cnt);

    // Stall holding a valid write
    drive(1'b1, 1'b1, 5'd9, 2'd0, 32'hCAFEBABE, 32'h0, 2'd0, 3'd0, 32'h300, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("pre_stall_wd", {32'h0, WD}, 64'hCAFEBABE);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 2'd3, 32'h1111 * (i + 1), 32'h0, 2'd0, 3'd0,
            32'h400 + 32'(i), 32'h5555 * (i + 1));
      step();
      chk($sformatf("stall%0d_rfwr", i), {63'h0, RFWr}, 64'd1);
      chk($sformatf("stall%0d_a3", i), {59'h0, A3}, 64'd9);
      chk($sformatf("stall%0d_wd", i), {32'h0, WD}, 64'hCAFEBABE);
      chk($sformatf("stall%0d_instret", i), instret, exp_cnt);
    end

    // Flush wins over stall
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 2'd0, 32'h77, 32'h0, 2'd0, 3'd0, 32'h500, 32'h0);
    step();
    chk("flush_valid", {63'h0, wb_valid}, 64'd0);
    chk("flush_rfwr", {63'h0, RFWr}, 64'd0);
    chk("flush_instret", instret, exp_cnt);
    stall = 1'b0;
    flush = 1'b0;

    // Async reset mid-write
    drive(1'b1, 1'b1, 5'd3, 2'd0, 32'h600D600D, 32'h0, 2'd0, 3'd0, 32'h600, 32'h0);
    step();
    chk("prerst_rfwr", {63'h0, RFWr}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rfwr", {63'h0, RFWr}, 64'd0);
    chk("arst_valid", {63'h0, wb_valid}, 64'd0);
    chk("arst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 2'd0, 32'h44, 32'h0, 2'd0, 3'd0, 32'h700, 32'h0);
    step();
    chk("postrst_instret", instret, 64'd1);
    chk("postrst_wd", {32'h0, WD}, 64'h44);

    // Counter wrap
    in_valid = 1'b0;
    step();
    dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    step();
    chk("wrap_instret", instret, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
